cnt_sched: RTL

Round-robin scheduler that shares one `counter` instance between `N_REQ` requesters. Each requester asks for a run of `len` counting cycles. The scheduler grants one requester at a time and clears the shared counter. It then drives the counter enable for exactly `len` cycles and pulses `done` back to the winner. It sits between the requesting control blocks and the counter's `cnt_rst_n` / `cnt_en` inputs.

---
 rtl/cnt_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cnt_sched.sv
// Round-robin arbiter that lends one shared counter to N_REQ requesters:
// it clears the counter, enables it for the winner's run length, then pulses done.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no grant; pick next requester round-robin from last+1
//   S_CLEAR | one cycle, counter cleared (sch_cnt_rst_n low)
//   S_RUN   | counter enabled, remain counts down to the final cycle
//   S_DONE  | one cycle, done pulse to the grantee
module cnt_sched #(
    parameter int N_REQ     = 4,
    parameter int LEN_WIDTH = 4,
    parameter int IDX_WIDTH = $clog2(N_REQ)
) (
    input  logic                       sch_clk,
    input  logic                       sch_rst,
    input  logic [N_REQ-1:0]           sch_req,
    input  logic [N_REQ*LEN_WIDTH-1:0] sch_len,
    output logic [N_REQ-1:0]           sch_gnt,
    output logic [IDX_WIDTH-1:0]       sch_gnt_idx,
    output logic [N_REQ-1:0]           sch_done,
    output logic                       sch_busy,
    output logic                       sch_cnt_rst_n,
    output logic                       sch_cnt_en
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     r_done;
    logic [N_REQ-1:0]     w_sel_oh;
    logic [IDX_WIDTH-1:0] r_gnt_idx;
    logic [IDX_WIDTH-1:0] r_last;
    logic [IDX_WIDTH-1:0] w_sel_idx;
    logic [IDX_WIDTH-1:0] w_cand;
    logic [IDX_WIDTH:0]   w_sum;
    logic [LEN_WIDTH-1:0] r_remain;
    logic [LEN_WIDTH-1:0] w_sel_len;
    logic                 w_sel_vld;
    logic                 w_req_held;

    assign w_req_held = |(sch_req & r_gnt);

    // Walk downward so the candidate closest to last+1 is the final one written.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + (IDX_WIDTH+1)'(k);
            if (w_sum >= (IDX_WIDTH+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_WIDTH+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_WIDTH-1:0];
            if (sch_req[w_cand]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_oh  = '0;
        w_sel_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_WIDTH'(i) == w_sel_idx) begin
                w_sel_oh[i] = 1'b1;
                w_sel_len   = sch_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    always_ff @(posedge sch_clk or posedge sch_rst) begin
        if (sch_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A dropped request during CLEAR or RUN aborts, even on the final RUN cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_sel_vld) w_next = S_CLEAR;
            S_CLEAR: begin
                if (!w_req_held)              w_next = S_IDLE;
                else if (r_remain == '0)      w_next = S_DONE;
                else                          w_next = S_RUN;
            end
            S_RUN: begin
                if (!w_req_held)                          w_next = S_IDLE;
                else if (r_remain == LEN_WIDTH'(1))       w_next = S_DONE;
                else                                      w_next = S_RUN;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sch_clk or posedge sch_rst) begin
        if (sch_rst) begin
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_last    <= IDX_WIDTH'(N_REQ - 1);
            r_remain  <= '0;
            r_done    <= '0;
        end else begin
            r_done <= (w_next == S_DONE) ? r_gnt : '0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_vld) begin
                        r_gnt     <= w_sel_oh;
                        r_gnt_idx <= w_sel_idx;
                        r_remain  <= w_sel_len;
                    end
                end
                S_RUN: begin
                    if (w_next != S_IDLE) r_remain <= r_remain - LEN_WIDTH'(1);
                end
                default: ;
            endcase
            if (r_state != S_IDLE && w_next == S_IDLE) begin
                r_gnt  <= '0;
                r_last <= r_gnt_idx;
            end
        end
    end

    always_comb begin
        sch_busy      = (r_state != S_IDLE);
        sch_cnt_rst_n = (r_state != S_CLEAR);
        sch_cnt_en    = (r_state == S_RUN) && w_req_held;
    end

    assign sch_gnt     = r_gnt;
    assign sch_gnt_idx = r_gnt_idx;
    assign sch_done    = r_done;

endmodule
